// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction queue sitting between the fetch stage and decode, in place of
// the plain IF/ID pipeline register. Fetch pushes {PC, instruction} pairs and
// decode consumes them in program order. The queue absorbs decode stalls so
// fetch only stalls once every slot is occupied. A taken redirect from
// Execute discards every queued (wrong-path) entry.
//
// Parameters
//   DEPTH  number of entries; power of two, >= 2
//   XLEN   PC width
//
// Ports
//   clk        in   1                 system clock, rising edge
//   rst        in   1                 asynchronous reset, active-low
//   Valid_F    in   1                 fetch presents an instruction this cycle
//   PC_F       in   XLEN              PC of the fetched instruction
//   Instr_F    in   32                fetched instruction
//   Full_F     out  1                 queue full; fetch must hold its instruction
//   PCSrc_E    in   1                 redirect taken in Execute; flush the queue
//   Stall_D    in   1                 decode cannot take the head entry this cycle
//   Valid_D    out  1                 head entry valid (queue not empty)
//   PC_D       out  XLEN              PC of the head entry (0 when empty)
//   PCPlus4_D  out  XLEN              PC_D + 4, modulo 2^XLEN
//   Instr_D    out  32                head instruction (NOP when empty)
//   Count      out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//
// Handshake semantics (both sides):
//   Fetch side : an entry is accepted on a rising edge when Valid_F = 1 and
//                Full_F = 0 and no flush is taking place. Full_F plays the role
//                of an inverted ready; it depends only on registered
//                occupancy, never on Valid_F, so there is no combinational
//                loop through the hazard unit.
//   Decode side: the head entry is consumed on a rising edge when Valid_D = 1
//                and Stall_D = 0 and no flush is taking place. Stall_D is an
//                inverted ready. Valid_D and the head data are stable for as
//                long as the entry is not consumed.
//   Flush      : PCSrc_E = 1 wins over both transfers in the same cycle.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  // fetch side
  input  logic                     Valid_F,
  input  logic [XLEN-1:0]          PC_F,
  input  logic [31:0]              Instr_F,
  output logic                     Full_F,
  // execute redirect
  input  logic                     PCSrc_E,
  // decode side
  input  logic                     Stall_D,
  output logic                     Valid_D,
  output logic [XLEN-1:0]          PC_D,
  output logic [XLEN-1:0]          PCPlus4_D,
  output logic [31:0]              Instr_D,
  // occupancy
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]   ONE_CNT   = CW'(1);
  localparam logic [AW-1:0]   ONE_PTR   = AW'(1);
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  // -------------------------------------------------------------------------
  // Flags: occupancy alone decides full/empty, so equal pointers are never
  // ambiguous and pointer wrap needs no extra state bit.
  // -------------------------------------------------------------------------
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  // A flush drops the F-side instruction (it is wrong-path) and also
  // suppresses the pop, because the head is about to be discarded anyway.
  assign push = Valid_F & ~full  & ~PCSrc_E;
  assign pop  = ~empty  & ~Stall_D & ~PCSrc_E;

  // -------------------------------------------------------------------------
  // Pointer and occupancy register. Reset is asynchronous so that an
  // in-flight queue is emptied immediately, not at the next edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (PCSrc_E) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + ONE_CNT;
        2'b01:   cnt <= cnt - ONE_CNT;
        default: cnt <= cnt;  // idle, or simultaneous push and pop
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage. Contents carry no reset: a slot is only ever read after
  // it has been written, because Valid_D gates every use of the head.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= PC_F;
      instr_mem[wr_ptr] <= Instr_F;
    end
  end

  // -------------------------------------------------------------------------
  // Head outputs: first-word fall-through from the read pointer. When the
  // queue is empty, decode sees a NOP at PC 0 so that downstream logic never
  // acts on stale storage.
  // -------------------------------------------------------------------------
  always_comb begin
    Valid_D = ~empty;
    PC_D    = '0;
    Instr_D = NOP_INSTR;
    if (!empty) begin
      PC_D    = pc_mem[rd_ptr];
      Instr_D = instr_mem[rd_ptr];
    end
  end

  assign PCPlus4_D = PC_D + PC_STEP;
  assign Full_F    = full;
  assign Count     = cnt;

endmodule
